// File: rtl/oled_seq_pkg.sv
// Shared types and constants for the SSD1306 OLED refresh sequencer.
package oled_seq_pkg;
  localparam logic [6:0]  DEV_ID   = 7'h3C;
  localparam logic [7:0]  CTRL_CMD = 8'h00;
  localparam logic [7:0]  CTRL_DAT = 8'h40;
  localparam int          INIT_LEN = 25;
  localparam int          PAGE_W   = 3;
  localparam int          COL_W    = 7;
  localparam logic [10:0] QTY_INIT = 11'(INIT_LEN + 1);
  localparam logic [10:0] QTY_CMD  = 11'd4;
  localparam logic [10:0] QTY_DAT  = 11'd129;

  typedef enum logic [3:0] {
    IDLE, INIT_ST, INIT_WT, CMD_ST, CMD_WT, DAT_ST, DAT_WT, DONE, ERR
  } state_t;
endpackage

// File: rtl/oled_init_rom.sv
// SSD1306 power-up command table, one byte per 5-bit index.
module oled_init_rom (
  input  logic [4:0] i_idx,
  output logic [7:0] o_data
);
  always_comb begin
    o_data = 8'h00;
    case (i_idx)
      5'd0:  o_data = 8'hAE;
      5'd1:  o_data = 8'hD5;
      5'd2:  o_data = 8'h80;
      5'd3:  o_data = 8'hA8;
      5'd4:  o_data = 8'h3F;
      5'd5:  o_data = 8'hD3;
      5'd6:  o_data = 8'h00;
      5'd7:  o_data = 8'h40;
      5'd8:  o_data = 8'h8D;
      5'd9:  o_data = 8'h14;
      5'd10: o_data = 8'h20;
      5'd11: o_data = 8'h02;
      5'd12: o_data = 8'hA1;
      5'd13: o_data = 8'hC8;
      5'd14: o_data = 8'hDA;
      5'd15: o_data = 8'h12;
      5'd16: o_data = 8'h81;
      5'd17: o_data = 8'hCF;
      5'd18: o_data = 8'hD9;
      5'd19: o_data = 8'hF1;
      5'd20: o_data = 8'hDB;
      5'd21: o_data = 8'h40;
      5'd22: o_data = 8'hA4;
      5'd23: o_data = 8'hA6;
      5'd24: o_data = 8'hAF;
      default: o_data = 8'h00;
    endcase
  end
endmodule

// File: rtl/oled_i2c_seq.sv
// Sequences INIT, then 8x(page CMD, page DAT) transactions into an I2C byte writer.
// Build option: OLED_SEQ_RETRY_EN retries a failed transaction up to 3 times.
module oled_i2c_seq
  import oled_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iGo,
  input  logic        iSkipInit,
  output logic [9:0]  oFbAddr,
  input  logic [7:0]  iFbData,
  output logic [6:0]  oDevID,
  output logic        oStart,
  output logic [10:0] oByteQnty,
  output logic [7:0]  oByteOut,
  input  logic [10:0] iByteCnt,
  input  logic        iAckErr,
  input  logic        iAction,
  output logic        oBusy,
  output logic        oDone,
  output logic        oErr
);
  state_t            r_state, w_nxt;
  logic [PAGE_W-1:0] r_page;
  logic [10:0]       r_qty;
  logic              r_act_d, r_txerr, r_done, r_err;
  logic              w_go, w_fall, w_txerr, w_in_wt, w_in_st, w_retry;
  logic [4:0]        w_rom_idx;
  logic [7:0]        w_rom_data, w_byte;
  logic [COL_W-1:0]  w_col;

  oled_init_rom u_rom (.i_idx(w_rom_idx), .o_data(w_rom_data));

  assign w_go    = (r_state == IDLE) && iGo;
  assign w_fall  = r_act_d && !iAction;
  // The writer clears iAckErr as iAction falls, so a same-cycle error still counts.
  assign w_txerr = r_txerr || iAckErr;
  assign w_in_st = (r_state == INIT_ST) || (r_state == CMD_ST) || (r_state == DAT_ST);
  assign w_in_wt = (r_state == INIT_WT) || (r_state == CMD_WT) || (r_state == DAT_WT);

`ifdef OLED_SEQ_RETRY_EN
  logic [1:0] r_retry;
  assign w_retry = (r_retry != 2'd3);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_retry <= 2'd0;
    else if (w_go)                    r_retry <= 2'd0;
    else if (w_in_wt && w_fall) begin
      if (!w_txerr)                   r_retry <= 2'd0;
      else if (w_retry)               r_retry <= r_retry + 2'd1;
    end
  end
`else
  assign w_retry = 1'b0;
`endif

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (iGo) w_nxt = iSkipInit ? CMD_ST : INIT_ST;
      INIT_ST: if (iAction) w_nxt = INIT_WT;
      CMD_ST:  if (iAction) w_nxt = CMD_WT;
      DAT_ST:  if (iAction) w_nxt = DAT_WT;
      INIT_WT: if (w_fall) w_nxt = w_txerr ? (w_retry ? INIT_ST : ERR) : CMD_ST;
      CMD_WT:  if (w_fall) w_nxt = w_txerr ? (w_retry ? CMD_ST : ERR) : DAT_ST;
      DAT_WT:  if (w_fall) begin
        if (w_txerr)                   w_nxt = w_retry ? DAT_ST : ERR;
        else if (r_page == PAGE_W'(7)) w_nxt = DONE;
        else                           w_nxt = CMD_ST;
      end
      DONE:    w_nxt = IDLE;
      ERR:     w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_page  <= '0;
      r_qty   <= '0;
      r_act_d <= 1'b0;
      r_txerr <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_act_d <= iAction;
      r_done  <= (r_state == DONE);
      if (w_go)
        r_page <= '0;
      else if (r_state == DAT_WT && w_fall && !w_txerr && r_page != PAGE_W'(7))
        r_page <= r_page + PAGE_W'(1);
      // Flag restarts with each attempt; accumulates for the whole active window.
      if (w_in_st)      r_txerr <= iAction && iAckErr;
      else if (iAction) r_txerr <= r_txerr || iAckErr;
      case (w_nxt)
        INIT_ST: r_qty <= QTY_INIT;
        CMD_ST:  r_qty <= QTY_CMD;
        DAT_ST:  r_qty <= QTY_DAT;
        default: r_qty <= r_qty;
      endcase
      if (w_go)              r_err <= 1'b0;
      else if (w_nxt == ERR) r_err <= 1'b1;
    end
  end

  assign w_rom_idx = iByteCnt[4:0] - 5'd1;
  assign w_col     = (iByteCnt == 11'd0) ? '0 : iByteCnt[COL_W-1:0] - COL_W'(1);

  always_comb begin
    w_byte  = 8'h00;
    oFbAddr = '0;
    case (r_state)
      INIT_ST, INIT_WT: begin
        if (iByteCnt == 11'd0)                 w_byte = CTRL_CMD;
        else if (iByteCnt <= 11'(INIT_LEN))    w_byte = w_rom_data;
      end
      CMD_ST, CMD_WT: begin
        case (iByteCnt)
          11'd0:   w_byte = CTRL_CMD;
          11'd1:   w_byte = 8'hB0 | {5'b0, r_page};
          11'd2:   w_byte = 8'h00;
          11'd3:   w_byte = 8'h10;
          default: w_byte = 8'h00;
        endcase
      end
      DAT_ST, DAT_WT: begin
        oFbAddr = {r_page, w_col};
        // Framebuffer RAM answers one clock after the address, which follows iByteCnt.
        w_byte  = (iByteCnt == 11'd0) ? CTRL_DAT : iFbData;
      end
      default: ;
    endcase
  end

  assign oByteOut  = w_byte;
  assign oDevID    = DEV_ID;
  assign oStart    = w_in_st;
  assign oByteQnty = r_qty;
  assign oBusy     = (r_state != IDLE);
  assign oDone     = r_done;
  assign oErr      = r_err;
endmodule
